// File: rtl/can_rx_fifo_param.sv
// Parametrised CAN receive-message FIFO with registered read data, flags and overrun tracking.
// Optional overrun event counter is enabled by defining RXFIFO_OVR_CNT_EN.
module can_rx_fifo_param #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 6,
  parameter int AFULL_TH = 48
) (
  input  logic              sys_clk,
  input  logic              IP2Can_reset,
  input  logic              flush,
  input  logic              load_data,
  input  logic [DATA_W-1:0] rxfifo_ip,
  input  logic              deload_data,
  output logic [DATA_W-1:0] rxfifo_op,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              RXNEMP,
  output logic              rxfifo_full,
  output logic              rxfifo_afull,
  output logic              overrun,
  input  logic              clr_ovr,
  output logic              underflow,
  output logic [7:0]        ovr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              empty;
  logic              do_rd;
  logic              do_wr;
  logic              ovr_set;

  assign empty        = (count == '0);
  assign RXNEMP       = ~empty;
  assign rxfifo_full  = (int'(count) == DEPTH);
  assign rxfifo_afull = (int'(count) >= AFULL_TH);

  // A read on a full FIFO frees a slot in the same cycle, so a concurrent write is accepted.
  assign do_rd   = deload_data & ~empty & ~flush;
  assign do_wr   = load_data & ~flush & (~rxfifo_full | do_rd);
  assign ovr_set = load_data & ~flush & rxfifo_full & ~do_rd;

  always_ff @(posedge sys_clk) begin
    if (do_wr) begin
      mem[wr_ptr[ADDR_W-1:0]] <= rxfifo_ip;
    end
  end

  always_ff @(posedge sys_clk or posedge IP2Can_reset) begin
    if (IP2Can_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rxfifo_op <= '0;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        if (do_wr && !do_rd) begin
          count <= count + PTR_ONE;
        end else if (!do_wr && do_rd) begin
          count <= count - PTR_ONE;
        end
      end
      rd_valid  <= do_rd;
      underflow <= deload_data & empty & ~flush;
      if (do_rd) begin
        rxfifo_op <= mem[rd_ptr[ADDR_W-1:0]];
      end
      // A new overrun in the same cycle as the clear keeps the flag set.
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef RXFIFO_OVR_CNT_EN
  always_ff @(posedge sys_clk or posedge IP2Can_reset) begin
    if (IP2Can_reset) begin
      ovr_cnt <= 8'd0;
    end else if (ovr_set) begin
      if (clr_ovr) begin
        ovr_cnt <= 8'd1;
      end else if (ovr_cnt != 8'hFF) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
    end else if (clr_ovr) begin
      ovr_cnt <= 8'd0;
    end
  end
`else
  assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_can_rx_fifo_param.sv
// Self-checking bench for can_rx_fifo_param (4-entry build): table-driven flags plus a read-data scoreboard.
module tb_can_rx_fifo_param;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              sys_clk = 1'b0;
  logic              IP2Can_reset;
  logic              flush;
  logic              load_data;
  logic [DATA_W-1:0] rxfifo_ip;
  logic              deload_data;
  logic [DATA_W-1:0] rxfifo_op;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              RXNEMP;
  logic              rxfifo_full;
  logic              rxfifo_afull;
  logic              overrun;
  logic              clr_ovr;
  logic              underflow;
  logic [7:0]        ovr_cnt;

  can_rx_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(3)) dut (
    .sys_clk     (sys_clk),
    .IP2Can_reset(IP2Can_reset),
    .flush       (flush),
    .load_data   (load_data),
    .rxfifo_ip   (rxfifo_ip),
    .deload_data (deload_data),
    .rxfifo_op   (rxfifo_op),
    .rd_valid    (rd_valid),
    .count       (count),
    .RXNEMP      (RXNEMP),
    .rxfifo_full (rxfifo_full),
    .rxfifo_afull(rxfifo_afull),
    .overrun     (overrun),
    .clr_ovr     (clr_ovr),
    .underflow   (underflow),
    .ovr_cnt     (ovr_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        ld;
    logic        dl;
    logic        fl;
    logic        co;
    logic [15:0] d;
    int          e_cnt;
    logic        e_full;
    logic        e_afull;
    logic        e_ovr;
    logic        e_unf;
    logic        e_rv;
    int          e_oc;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_data;
  int          model_cnt;
  logic        exp_rv;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests and update the bench's own occupancy/data model.
  task automatic applyStimulus(input logic ld, input logic dl, input logic fl,
                               input logic co, input logic [15:0] d);
    logic rd_ok;
    logic wr_ok;
    @(negedge sys_clk);
    load_data   = ld;
    deload_data = dl;
    flush       = fl;
    clr_ovr     = co;
    rxfifo_ip   = d;
    rd_ok = dl && (model_cnt > 0) && !fl;
    wr_ok = ld && !fl && ((model_cnt < DEPTH) || rd_ok);
    exp_rv = rd_ok;
    if (fl) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (wr_ok) begin
        exp_q.push_back(d);
        model_cnt++;
      end
      if (rd_ok) model_cnt--;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    int exp_oc;
`ifdef RXFIFO_OVR_CNT_EN
    exp_oc = v.e_oc;
`else
    exp_oc = 0;
`endif
    if (exp_rv) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s scoreboard: read expected but no data queued", tag);
      end else begin
        last_data = exp_q.pop_front();
      end
    end
    check({tag, " count"},     32'(count),        32'(v.e_cnt));
    check({tag, " model_cnt"}, 32'(count),        32'(model_cnt));
    check({tag, " RXNEMP"},    32'(RXNEMP),       32'(v.e_cnt != 0));
    check({tag, " full"},      32'(rxfifo_full),  32'(v.e_full));
    check({tag, " afull"},     32'(rxfifo_afull), 32'(v.e_afull));
    check({tag, " overrun"},   32'(overrun),      32'(v.e_ovr));
    check({tag, " underflow"}, 32'(underflow),    32'(v.e_unf));
    check({tag, " rd_valid"},  32'(rd_valid),     32'(v.e_rv));
    check({tag, " rxfifo_op"}, 32'(rxfifo_op),    32'(last_data));
    check({tag, " ovr_cnt"},   32'(ovr_cnt),      32'(exp_oc));
  endtask

  function automatic vec_t mk(logic ld, logic dl, logic fl, logic co, logic [15:0] d,
                              int c, logic f, logic af, logic ov, logic uf, logic rv, int oc);
    vec_t v;
    v.ld = ld; v.dl = dl; v.fl = fl; v.co = co; v.d = d;
    v.e_cnt = c; v.e_full = f; v.e_afull = af; v.e_ovr = ov;
    v.e_unf = uf; v.e_rv = rv; v.e_oc = oc;
    return v;
  endfunction

  initial begin
    vec_t v;
    n_checks    = 0;
    n_fail      = 0;
    model_cnt   = 0;
    exp_rv      = 1'b0;
    last_data   = '0;
    flush       = 1'b0;
    load_data   = 1'b0;
    deload_data = 1'b0;
    clr_ovr     = 1'b0;
    rxfifo_ip   = '0;
    IP2Can_reset = 1'b1;

    //        ld dl fl co data     cnt full afull ovr unf rv oc
    vecs.push_back(mk(1, 0, 0, 0, 16'h0001, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0002, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0003, 3, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0004, 4, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0005, 4, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0055, 4, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 3, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0066, 1, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0071, 1, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0072, 2, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0073, 3, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0074, 4, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0075, 4, 1, 1, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0081, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0082, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0083, 3, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0084, 4, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0085, 4, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 16'h0086, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput(mk(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0), "reset");
    @(negedge sys_clk);
    IP2Can_reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ld, vecs[i].dl, vecs[i].fl, vecs[i].co, vecs[i].d);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Write-then-read ten times so both pointers wrap past the 3-bit range.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h00A0 + i));
      checkOutput(mk(0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0), $sformatf("wrap_wr%0d", i));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput(mk(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 1, 0), $sformatf("wrap_rd%0d", i));
    end
    check("wrap last word", 32'(last_data), 32'h00A9);

    // Asynchronous reset landing between edges while data is valid on the read port.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h00B1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h00B2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h00B3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput(mk(0, 0, 0, 0, 16'h0, 2, 0, 0, 0, 0, 1, 0), "pre_reset");
    load_data   = 1'b0;
    deload_data = 1'b0;
    #1;
    IP2Can_reset = 1'b1;
    #1;
    exp_q.delete();
    model_cnt = 0;
    exp_rv    = 1'b0;
    last_data = '0;
    checkOutput(mk(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0), "mid_reset");
    @(negedge sys_clk);
    IP2Can_reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h00C1);
    checkOutput(mk(0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0), "post_reset_wr");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput(mk(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 1, 0), "post_reset_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/can_rx_fifo_param.md
Name: can_rx_fifo_param

Overview:
- Parametrised receive-message FIFO for the CAN core. Sits between the Rx message assembler (writer) and the host register interface (reader).
- Generalises the fixed 128x64 Rx store. Adds:
  - configurable width and depth
  - true simultaneous load/deload
  - full and almost-full flags
  - overrun and underflow detection
  - synchronous flush
  - registered read data with a valid strobe

Parameters:
- DATA_W, 128, message word width in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries (64 by default). All entries are usable.
- AFULL_TH, 48, occupancy at or above which rxfifo_afull asserts. Legal range 1..DEPTH.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- IP2Can_reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pointers and count; storage contents don't-care.
- load_data  in  1  write request; rxfifo_ip captured on the same edge.
- rxfifo_ip  in  DATA_W  write data.
- deload_data  in  1  read request.
- rxfifo_op  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse: rxfifo_op updated this cycle.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- RXNEMP  out  1  FIFO not empty (count != 0).
- rxfifo_full  out  1  count == DEPTH.
- rxfifo_afull  out  1  count >= AFULL_TH.
- overrun  out  1  sticky; set on a write attempted while full.
- clr_ovr  in  1  synchronous clear of overrun.
- underflow  out  1  one-cycle pulse on a read attempted while empty.
- ovr_cnt  out  8  overrun event counter (see Optional Feature).

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide.
  - The MSB distinguishes full from empty; the low ADDR_W bits address storage.
  - Wrap-around is natural modulo 2**(ADDR_W+1). There is no special-case reset at DEPTH-1.
- count = wr_ptr - rd_ptr, registered, within range 0..DEPTH. RXNEMP, rxfifo_full and rxfifo_afull are decoded from the registered count, so they are valid in the cycle after the causing edge.
- Reset (async assert; deassertion is synchronised externally):
  - pointers, count, rxfifo_op, rd_valid, overrun, underflow and ovr_cnt all go to 0.
  - RXNEMP, full and afull therefore read 0.
  - Storage is not reset.
- Write: if load_data=1 and not full, mem[wr_ptr] <= rxfifo_ip and wr_ptr increments.
- Write while full: data is dropped, wr_ptr is held, overrun <= 1.
- Read: if deload_data=1 and not empty, rxfifo_op <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 in the next cycle. Read latency is 1 clock from request to data.
- Read while empty: rxfifo_op holds, rd_valid=0, underflow pulses for 1 cycle.
- Simultaneous load and deload:
  - Both are performed, so count is unchanged.
  - When full, the read frees a slot in the same cycle, so the write is accepted and overrun is not set.
  - When empty, the read is rejected (underflow) and the write is accepted; count becomes 1.
  - There is no write-to-read bypass in the same cycle.
- flush:
  - Takes priority over load and deload in the same cycle.
  - Zeroes pointers and count and clears rd_valid.
  - Does not clear overrun or ovr_cnt.
- overrun priority: a set in the same cycle as clr_ovr wins (overrun stays 1).
- Idle: no request means no state change.

Optional Feature:
- Macro: RXFIFO_OVR_CNT_EN.
- Defined:
  - ovr_cnt increments on each dropped write and saturates at 255.
  - It clears on reset and on clr_ovr; an increment in the same cycle as clr_ovr wins and the counter becomes 1.
- Undefined: ovr_cnt is tied to 8'd0 and no counter flops are generated.

Test Plan:
- Reset mid-operation: write 3 words, assert IP2Can_reset asynchronously between edges -> all outputs 0 immediately; count=0, RXNEMP=0.
- Fill and drain (ADDR_W=2, AFULL_TH=3): write 0x1..0x4 -> afull at count=3, full at count=4. A 5th write of 0x5 is dropped and sets overrun (ovr_cnt=1 if enabled). Reads return 0x1,0x2,0x3,0x4, each with rd_valid one cycle after deload.
- Wrap-around (ADDR_W=2): 10 cycles of write-then-read of 0xA0+i -> reads return 0xA0..0xA9 in order; count never exceeds 1; no flags set.
- Simultaneous at full (ADDR_W=2): with count=4, assert load(0x55) and deload together -> oldest word out, count stays 4, overrun=0. After draining, 0x55 is the last word read.
- Empty edge cases: deload with count=0 -> underflow pulse, rd_valid=0, rxfifo_op unchanged. Load and deload together when empty -> count=1, underflow=1.
- Flush and clr_ovr: with overrun=1 and count=4, pulse flush -> count=0, RXNEMP=0, overrun still 1. Pulse clr_ovr -> overrun=0, ovr_cnt=0 (enabled build).
